// File: rtl/cipher_session_ctrl.sv
// Session sequencer for the byte-wide stream cipher core: loads the key
// byte-serially, seeds the core, streams bytes through a one-entry output
// register (XOR with keystream) and forces a reseed every REKEY_INTERVAL bytes.
//
// Handshakes (cmd, in, out) all use the same rule: a transfer happens on a
// rising edge where valid & ready & ena are all high. Valid must not wait for
// ready; ready may depend on valid-independent state only (cmd_ready in
// KEYLOAD looks at cmd_op, never at cmd_valid). ena=0 blocks every transfer
// and freezes every register.
module cipher_session_ctrl #(
    parameter int KEY_BYTES      = 4,
    parameter int REKEY_INTERVAL = 256,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       core_key_byte,
    output logic             core_key_we,
    output logic             core_seed,
    output logic             core_step,
    input  logic [7:0]       core_ks,
    input  logic             core_ks_valid,
    output logic [1:0]       mode,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count,
    output logic             err,
    output logic [2:0]       state_dbg
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ENC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;

    localparam int             KI_W      = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KI_W-1:0] KEY_LAST = KI_W'(KEY_BYTES - 1);
    localparam bit             REKEY_EN  = (REKEY_INTERVAL != 0);
    localparam logic [CNT_W-1:0] REKEY_CNT = CNT_W'(REKEY_INTERVAL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_KEYLOAD = 3'd1,
        S_SEED    = 3'd2,
        S_WAIT_KS = 3'd3,
        S_STREAM  = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [KI_W-1:0] key_idx;
    logic            key_loaded;
    logic            reseed;      // distinguishes a reseed from the initial key seed
    logic            rekey_due;
    logic            cmd_fire;
    logic            in_fire;

    assign rekey_due     = REKEY_EN && (byte_count == REKEY_CNT);
    assign cmd_fire      = cmd_valid & cmd_ready;
    assign in_fire       = in_valid & in_ready;
    assign core_key_byte = in_data;
    assign busy          = (state_q != S_IDLE);
    assign state_dbg     = state_q;

    // Ready generation per state; everything is gated off while ena is low.
    always_comb begin
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready = 1'b1;
                end
                S_KEYLOAD: begin
                    cmd_ready = (cmd_op == OP_STOP);
                    in_ready  = 1'b1;
                end
                S_STREAM: begin
                    cmd_ready = !out_valid;
                    in_ready  = core_ks_valid & (!out_valid | out_ready) & !rekey_due;
                end
                default: begin
                    cmd_ready = 1'b0;
                    in_ready  = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic and the single-cycle core strobes.
    always_comb begin
        state_d     = state_q;
        core_key_we = 1'b0;
        core_seed   = 1'b0;
        core_step   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_op == OP_LOAD)
                        state_d = S_KEYLOAD;
                    else if ((cmd_op == OP_ENC || cmd_op == OP_DEC) && key_loaded)
                        state_d = S_STREAM;
                end
            end
            S_KEYLOAD: begin
                core_key_we = in_fire;
                if (cmd_fire)
                    state_d = S_IDLE;
                else if (in_fire && key_idx == KEY_LAST)
                    state_d = S_SEED;
            end
            S_SEED: begin
                core_seed = ena;
                state_d   = S_WAIT_KS;
            end
            S_WAIT_KS: begin
                if (core_ks_valid)
                    state_d = reseed ? S_STREAM : S_IDLE;
            end
            S_STREAM: begin
                core_step = in_fire;
                // STOP wins over a pending reseed
                if (cmd_fire && cmd_op == OP_STOP)
                    state_d = S_IDLE;
                else if (rekey_due && !out_valid)
                    state_d = S_SEED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else if (ena)
            state_q <= state_d;
    end

    // Session bookkeeping: key index, key_loaded, err, mode, reseed flag, byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_idx    <= '0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
            mode       <= 2'b00;
            reseed     <= 1'b0;
            byte_count <= '0;
        end else if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_op == OP_LOAD) begin
                            key_idx    <= '0;
                            key_loaded <= 1'b0;
                            err        <= 1'b0;
                            reseed     <= 1'b0;
                        end else if (cmd_op == OP_ENC || cmd_op == OP_DEC) begin
                            if (key_loaded)
                                mode <= cmd_op;
                            else
                                err <= 1'b1;
                        end
                    end
                end
                S_KEYLOAD: begin
                    if (in_fire)
                        key_idx <= key_idx + KI_W'(1);
                end
                S_SEED: begin
                    byte_count <= '0;
                end
                S_WAIT_KS: begin
                    if (core_ks_valid && !reseed)
                        key_loaded <= 1'b1;
                end
                S_STREAM: begin
                    if (in_fire)
                        byte_count <= byte_count + CNT_W'(1);
                    if (state_d == S_IDLE)
                        mode <= 2'b00;
                    else if (state_d == S_SEED)
                        reseed <= 1'b1;
                end
                default: begin
                    key_idx <= key_idx;
                end
            endcase
        end
    end

    // One-entry output register: load on a stream accept, drain on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
        end else if (ena) begin
            if (in_fire && state_q == S_STREAM) begin
                out_data  <= in_data ^ core_ks;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cipher_session_ctrl.sv
// Directed bench for cipher_session_ctrl with a small rekey interval so the
// reseed path is reached quickly. Output bytes go through an expected queue.
module tb_cipher_session_ctrl;

    localparam int KEY_BYTES      = 4;
    localparam int REKEY_INTERVAL = 4;
    localparam int CNT_W          = 16;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ENC  = 2'b01;
    localparam logic [1:0] OP_STOP = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_KEYLOAD = 3'd1;
    localparam logic [2:0] ST_SEED    = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_STREAM  = 3'd4;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic             cmd_ready;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       core_key_byte;
    logic             core_key_we;
    logic             core_seed;
    logic             core_step;
    logic [7:0]       core_ks;
    logic             core_ks_valid;
    logic [1:0]       mode;
    logic             busy;
    logic [CNT_W-1:0] byte_count;
    logic             err;
    logic [2:0]       state_dbg;

    int total = 0;
    int bad   = 0;
    int seed_cnt = 0;
    int we_cnt   = 0;
    int step_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    cipher_session_ctrl #(
        .KEY_BYTES(KEY_BYTES),
        .REKEY_INTERVAL(REKEY_INTERVAL),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_key_byte(core_key_byte), .core_key_we(core_key_we),
        .core_seed(core_seed), .core_step(core_step),
        .core_ks(core_ks), .core_ks_valid(core_ks_valid),
        .mode(mode), .busy(busy), .byte_count(byte_count), .err(err),
        .state_dbg(state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Strobe counters and output scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && ena) begin
            if (core_seed)   seed_cnt++;
            if (core_key_we) we_cnt++;
            if (core_step)   step_cnt++;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected got=%h required=none", out_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (out_data !== exp_b) begin
                        bad++;
                        $display("FAIL out_data got=%h required=%h", out_data, exp_b);
                    end
                end
            end
        end
    end

    // Driver tasks (all start and end at posedge+1)
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        logic fired;
        fired = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = op;
        for (int i = 0; i < 20 && !fired; i++) begin
            #1;
            fired = cmd_ready;
            cyc();
        end
        cmd_valid = 1'b0;
        total++;
        if (!fired) begin
            bad++;
            $display("FAIL cmd_accept op=%0d got=stalled required=accepted", op);
        end
    endtask

    task automatic feed_byte(input logic [7:0] d);
        logic fired;
        fired = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 20 && !fired; i++) begin
            #1;
            fired = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        total++;
        if (!fired) begin
            bad++;
            $display("FAIL in_accept data=%h got=stalled required=accepted", d);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if ({cmd_ready, in_ready, out_valid, busy, err} !== 5'b10000) begin bad++; $display("FAIL reset_flags got=%b required=%b", {cmd_ready, in_ready, out_valid, busy, err}, 5'b10000); end
        total++; if ({core_key_we, core_seed, core_step} !== 3'b000) begin bad++; $display("FAIL reset_strobes got=%b required=000", {core_key_we, core_seed, core_step}); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h required=00", out_data); end
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL reset_mode got=%b required=00", mode); end
        total++; if (byte_count !== 16'd0) begin bad++; $display("FAIL reset_byte_count got=%0d required=0", byte_count); end
        total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d required=%0d", state_dbg, ST_IDLE); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_no_key();
        send_cmd(OP_ENC);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL nokey_err got=%b required=1", err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL nokey_busy got=%b required=0", busy); end
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL nokey_mode got=%b required=00", mode); end
    endtask

    task automatic test_key_load();
        logic [7:0] key_bytes [4];
        int we0;
        int seed0;
        key_bytes[0] = 8'h11; key_bytes[1] = 8'h22; key_bytes[2] = 8'h33; key_bytes[3] = 8'h44;
        core_ks_valid = 1'b0;
        send_cmd(OP_LOAD);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL load_err_clear got=%b required=0", err); end
        total++; if (state_dbg !== ST_KEYLOAD) begin bad++; $display("FAIL load_state got=%0d required=%0d", state_dbg, ST_KEYLOAD); end
        we0 = we_cnt;
        seed0 = seed_cnt;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data = key_bytes[k];
            if (k == 0) begin
                cmd_valid = 1'b1;
                cmd_op = OP_ENC;
            end
            #1;
            if (k == 0) begin
                total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL load_cmd_blocked got=%b required=0", cmd_ready); end
            end
            total++; if ({in_ready, core_key_we} !== 2'b11) begin bad++; $display("FAIL load_we byte=%0d got=%b required=11", k, {in_ready, core_key_we}); end
            total++; if (core_key_byte !== key_bytes[k]) begin bad++; $display("FAIL load_key_byte byte=%0d got=%h required=%h", k, core_key_byte, key_bytes[k]); end
            cmd_valid = 1'b0;
            cyc();
        end
        in_valid = 1'b0;
        total++; if ({state_dbg, core_seed} !== {ST_SEED, 1'b1}) begin bad++; $display("FAIL load_seed got=%0d/%b required=%0d/1", state_dbg, core_seed, ST_SEED); end
        cyc();
        total++; if ({state_dbg, core_seed} !== {ST_WAIT, 1'b0}) begin bad++; $display("FAIL load_wait got=%0d/%b required=%0d/0", state_dbg, core_seed, ST_WAIT); end
        total++; if (we_cnt - we0 !== 4) begin bad++; $display("FAIL load_we_count got=%0d required=4", we_cnt - we0); end
        total++; if (seed_cnt - seed0 !== 1) begin bad++; $display("FAIL load_seed_count got=%0d required=1", seed_cnt - seed0); end
        cyc();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL load_hold_wait got=%b required=1", busy); end
        core_ks = 8'hA5;
        core_ks_valid = 1'b1;
        cyc();
        total++; if ({busy, err} !== 2'b00) begin bad++; $display("FAIL load_done got=%b required=00", {busy, err}); end
        total++; if (byte_count !== 16'd0) begin bad++; $display("FAIL load_byte_count got=%0d required=0", byte_count); end
    endtask

    task automatic test_encrypt();
        int s0;
        send_cmd(OP_ENC);
        total++; if ({state_dbg, mode, err} !== {ST_STREAM, 2'b01, 1'b0}) begin bad++; $display("FAIL enc_enter got=%b required=%b", {state_dbg, mode, err}, {ST_STREAM, 2'b01, 1'b0}); end
        s0 = step_cnt;
        exp_q.push_back(8'hA4);
        exp_q.push_back(8'hA7);
        exp_q.push_back(8'hA6);
        feed_byte(8'h01);
        feed_byte(8'h02);
        feed_byte(8'h03);
        cyc();
        cyc();
        total++; if (byte_count !== 16'd3) begin bad++; $display("FAIL enc_byte_count got=%0d required=3", byte_count); end
        total++; if (step_cnt - s0 !== 3) begin bad++; $display("FAIL enc_step_count got=%0d required=3", step_cnt - s0); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL enc_drained got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_rekey();
        int seed0;
        logic got;
        seed0 = seed_cnt;
        exp_q.push_back(8'hB5);
        feed_byte(8'h10);
        in_valid = 1'b1;
        in_data = 8'h20;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rekey_in_ready got=%b required=0", in_ready); end
        total++; if (byte_count !== 16'd4) begin bad++; $display("FAIL rekey_count_full got=%0d required=4", byte_count); end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc();
            got = core_seed;
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL rekey_seed got=none required=pulse"); end
        core_ks_valid = 1'b0;
        cyc();
        total++; if ({state_dbg, core_seed, in_ready} !== {ST_WAIT, 2'b00}) begin bad++; $display("FAIL rekey_wait got=%b required=%b", {state_dbg, core_seed, in_ready}, {ST_WAIT, 2'b00}); end
        total++; if (byte_count !== 16'd0) begin bad++; $display("FAIL rekey_count_clear got=%0d required=0", byte_count); end
        total++; if (seed_cnt - seed0 !== 1) begin bad++; $display("FAIL rekey_seed_count got=%0d required=1", seed_cnt - seed0); end
        cyc();
        core_ks_valid = 1'b1;
        cyc();
        total++; if (state_dbg !== ST_STREAM) begin bad++; $display("FAIL rekey_resume got=%0d required=%0d", state_dbg, ST_STREAM); end
        exp_q.push_back(8'h85);
        feed_byte(8'h20);
        cyc();
        cyc();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rekey_drained got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        exp_q.push_back(8'hA4);
        feed_byte(8'h01);
        in_valid = 1'b1;
        in_data = 8'h02;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b required=0", in_ready); end
        cyc();
        cyc();
        total++; if ({out_valid, out_data} !== {1'b1, 8'hA4}) begin bad++; $display("FAIL bp_hold got=%b/%h required=1/a4", out_valid, out_data); end
        total++; if (byte_count !== 16'd2) begin bad++; $display("FAIL bp_count got=%0d required=2", byte_count); end
        exp_q.push_back(8'hA7);
        exp_q.push_back(8'hA6);
        out_ready = 1'b1;
        feed_byte(8'h02);
        feed_byte(8'h03);
        total++; if (byte_count !== 16'd4) begin bad++; $display("FAIL bp_count_end got=%0d required=4", byte_count); end
        repeat (6) cyc();
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL bp_drained got=%0d required=0", exp_q.size()); end
        total++; if ({state_dbg, byte_count} !== {ST_STREAM, 16'd0}) begin bad++; $display("FAIL bp_auto_reseed got=%0d/%0d required=%0d/0", state_dbg, byte_count, ST_STREAM); end
    endtask

    task automatic test_stop();
        logic done;
        out_ready = 1'b0;
        exp_q.push_back(8'hAA);
        feed_byte(8'h0F);
        cmd_valid = 1'b1;
        cmd_op = OP_STOP;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL stop_blocked got=%b required=0", cmd_ready); end
        cyc();
        cyc();
        total++; if ({mode, busy} !== 3'b011) begin bad++; $display("FAIL stop_pending got=%b required=011", {mode, busy}); end
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            cyc();
            done = !busy;
        end
        cmd_valid = 1'b0;
        total++; if ({done, mode} !== 3'b100) begin bad++; $display("FAIL stop_done got=%b required=100", {done, mode}); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stop_drained got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_ena();
        send_cmd(OP_ENC);
        out_ready = 1'b0;
        exp_q.push_back(8'hFF);
        feed_byte(8'h5A);
        ena = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11;
        cmd_valid = 1'b1;
        cmd_op = OP_STOP;
        #1;
        total++; if ({in_ready, cmd_ready, core_step, core_seed} !== 4'b0000) begin bad++; $display("FAIL ena_gates got=%b required=0000", {in_ready, cmd_ready, core_step, core_seed}); end
        repeat (3) cyc();
        total++; if ({out_valid, out_data} !== {1'b1, 8'hFF}) begin bad++; $display("FAIL ena_hold_out got=%b/%h required=1/ff", out_valid, out_data); end
        total++; if (byte_count !== 16'd2) begin bad++; $display("FAIL ena_hold_count got=%0d required=2", byte_count); end
        total++; if ({state_dbg, mode} !== {ST_STREAM, 2'b01}) begin bad++; $display("FAIL ena_hold_state got=%b required=%b", {state_dbg, mode}, {ST_STREAM, 2'b01}); end
        ena = 1'b1;
        in_valid = 1'b0;
        cmd_valid = 1'b0;
        cyc();
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ena_resume got=%b required=0", out_valid); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL ena_drained got=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        feed_byte(8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({out_valid, busy, err, in_ready, cmd_ready} !== 5'b00001) begin bad++; $display("FAIL rst_mid_flags got=%b required=00001", {out_valid, busy, err, in_ready, cmd_ready}); end
        total++; if ({out_data, mode} !== 10'd0) begin bad++; $display("FAIL rst_mid_data got=%h/%b required=00/00", out_data, mode); end
        total++; if (byte_count !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%0d required=0", byte_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
        send_cmd(OP_ENC);
        total++; if ({err, busy, mode} !== 4'b1000) begin bad++; $display("FAIL rst_mid_key_lost got=%b required=1000", {err, busy, mode}); end
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = OP_LOAD;
        in_data = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b1;
        core_ks = 8'hA5;
        core_ks_valid = 1'b1;
        test_reset();
        test_no_key();
        test_key_load();
        test_encrypt();
        test_rekey();
        test_backpressure();
        test_stop();
        test_ena();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cipher_session_ctrl.md
# cipher_session_ctrl

Session sequencer for the byte-wide stream cipher core. It accepts host commands and loads the key byte-serially into the core, then seeds it. During a session it moves plaintext and ciphertext bytes through a one-entry output register, XORing each byte with the core keystream. It forces a reseed every REKEY_INTERVAL bytes.

## Interface
- KEY_BYTES, 4: key length in bytes (≥1).
- REKEY_INTERVAL, 256: bytes per seed before a forced reseed. 0 disables reseeding.
- CNT_W, 16: byte counter width. REKEY_INTERVAL < 2^CNT_W.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable. Low freezes all state.
- cmd_valid  in  1  command handshake valid.
- cmd_op  in  2  00 LOAD_KEY, 01 ENCRYPT, 10 DECRYPT, 11 STOP.
- cmd_ready  out  1  command handshake ready.
- in_data  in  8  key byte or message byte.
- in_valid  in  1  input handshake valid.
- in_ready  out  1  input handshake ready.
- out_data  out  8  processed byte, registered.
- out_valid  out  1  output handshake valid.
- out_ready  in  1  output handshake ready.
- core_key_byte  out  8  key byte to core (= in_data).
- core_key_we  out  1  key byte write strobe.
- core_seed  out  1  one-cycle seed/reseed pulse.
- core_step  out  1  advance keystream one byte.
- core_ks  in  8  current keystream byte.
- core_ks_valid  in  1  core_ks usable.
- mode  out  2  01 encrypt, 10 decrypt, 00 idle.
- busy  out  1  state ≠ IDLE.
- byte_count  out  CNT_W  bytes since last seed.
- err  out  1  sticky: encrypt/decrypt requested with no key loaded.

## Operation
- Handshakes:
  - A transfer occurs on a cycle with valid & ready & ena.
  - ena=0 forces cmd_ready, in_ready, core_key_we, core_seed and core_step to 0.
  - ena=0 holds all registers, including a pending out_valid.
- States: IDLE, KEYLOAD, SEED, WAIT_KS, STREAM.
- IDLE: cmd_ready=1, in_ready=0.
  - LOAD_KEY → KEYLOAD. Clears key index, key_loaded and err.
  - ENCRYPT/DECRYPT with key_loaded=1 → STREAM; latch mode.
  - ENCRYPT/DECRYPT with key_loaded=0: set err, stay in IDLE. The command is consumed.
  - STOP: no-op.
- KEYLOAD: in_ready=1.
  - Each accepted byte asserts core_key_we in the same cycle, with core_key_byte=in_data.
  - After the KEY_BYTES-th byte → SEED.
  - cmd_ready=1 for STOP only → IDLE, key_loaded stays 0. Other ops in KEYLOAD hold cmd_ready low.
- SEED: core_seed=1 for exactly one cycle; byte_count cleared → WAIT_KS.
- WAIT_KS: wait for core_ks_valid=1.
  - Initial load: set key_loaded → IDLE.
  - Reseed: → STREAM.
- STREAM:
  - in_ready = core_ks_valid & (!out_valid | out_ready) & !rekey_due.
  - On accept: out_data ← in_data XOR core_ks; out_valid ← 1; core_step=1 same cycle; byte_count+1.
  - Encrypt and decrypt are the same XOR; mode is exported for the core and for visibility.
  - rekey_due = (REKEY_INTERVAL≠0) & (byte_count==REKEY_INTERVAL).
  - When rekey_due and out_valid=0 → SEED.
  - REKEY_INTERVAL=0: byte_count wraps modulo 2^CNT_W.
  - cmd_ready=1 only when out_valid=0. Only STOP changes state (→ IDLE, mode←00); other ops are consumed and ignored.
  - STOP takes priority over a pending reseed.
- Output register:
  - out_valid clears on out_ready when no new accept occurs.
  - Accept together with out_ready replaces the data and keeps out_valid=1.

## Timing
- Reset values:
  - state IDLE.
  - out_data, out_valid, mode, busy, byte_count, err = 0.
  - key_loaded=0.
  - core_key_we, core_seed, core_step = 0.
  - cmd_ready=ena, in_ready=0.
- Datapath latency: accept at cycle t → out_valid/out_data at t+1. Full throughput is 1 byte/cycle.
- Key load:
  - Last key accept at t → core_seed at t+1 → WAIT_KS from t+2.
  - IDLE the cycle after core_ks_valid is sampled high.
- Reseed bubble: at least 2 cycles plus the core's keystream-valid latency.
- Reset mid-operation: immediate return to reset values. The key must be reloaded.

## Test plan
- Key load: LOAD_KEY, then bytes 0x11,0x22,0x33,0x44 → four core_key_we pulses carrying those bytes, one core_seed pulse, key_loaded=1, back to IDLE.
- Encrypt stream, core_ks fixed 0xA5: inputs 0x01,0x02,0x03 → outputs 0xA4,0xA7,0xA6, three core_step pulses, byte_count=3.
- Backpressure: out_ready=0 after the first output → in_ready=0 and out_data held at 0xA4. out_ready=1 → stream resumes with no loss or duplication.
- No key: ENCRYPT after reset → err=1, state IDLE, mode=00. A following LOAD_KEY clears err.
- Rekey with REKEY_INTERVAL=4: 4 bytes → in_ready drops, core_seed pulses once, byte_count=0, and streaming resumes after core_ks_valid.
- STOP and ena: STOP with out_valid=1 stays unaccepted until drained, then mode=00. ena=0 mid-stream freezes state, out_valid and byte_count. rst_n low mid-stream → all outputs return to reset values asynchronously.
